// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes packed BCD digits onto one seven-segment decoder with tear-free frame loads
module bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1,
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lz_en,
  input  logic                  blank_all,
  output logic                  D,
  output logic                  C,
  output logic                  B,
  output logic                  A,
  output logic                  BI,
  output logic [DIGITS-1:0]     dig_en,
  output logic [IW-1:0]         digit_idx,
  output logic                  load_ack,
  output logic                  frame_start
);
  logic [PW-1:0] ps;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] shadow, pending;
  logic pend_v, active, blank_q, lz_q, upper_nz, tick, wrap;
  assign tick = ps == PW'(SCAN_DIV - 1);
  assign wrap = tick && (!active || idx == IW'(DIGITS - 1));
  // blank_all/lz_en are registered so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps          <= '0;
      idx         <= '0;
      shadow      <= '0;
      pending     <= '0;
      pend_v      <= 1'b0;
      active      <= 1'b0;
      blank_q     <= 1'b0;
      lz_q        <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ps          <= tick ? '0 : ps + 1'b1;
      blank_q     <= blank_all;
      lz_q        <= lz_en;
      frame_start <= wrap;
      load_ack    <= wrap && (load || pend_v);
      if (tick) begin
        active <= 1'b1;
        idx    <= wrap ? '0 : idx + 1'b1;
      end
      if (load) pending <= bcd_in;
      if (wrap) begin
        pend_v <= 1'b0;
        if (load) shadow <= bcd_in;
        else if (pend_v) shadow <= pending;
      end else if (load) pend_v <= 1'b1;
    end
  end
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (IW'(i) >= idx && shadow[4*i +: 4] != 4'd0) upper_nz = 1'b1;
  end
  assign {D, C, B, A} = shadow[{idx, 2'b00} +: 4];
  assign dig_en      = (active && !blank_q && int'(ps) < SCAN_DIV - GUARD) ? DIGITS'(1) << idx : '0;
  assign BI          = active && !blank_q && !(lz_q && idx != '0 && !upper_nz);
  assign digit_idx   = idx;
endmodule
